// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared FSM state, byte-lane constant and command record for wb_cmd_master
package wb_cmd_pkg;
  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  localparam int CMD_LEN_W = 4;
  localparam int CMD_BYTES = CMD_DW / 8;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  typedef struct packed {
    logic                 we;
    logic [CMD_BYTES-1:0] sel;
    logic [CMD_AW-1:0]    adr;
    logic [CMD_DW-1:0]    wdata;
    logic [CMD_LEN_W-1:0] len;
  } cmd_t;
endpackage

// File: rtl/wb_cmd_beat_ctr.sv
// wb_cmd_beat_ctr: beat index of a burst, derived beat address and last-beat flag
// clk/rst: clock, sync active-high reset; clr: restart at beat 0; step: advance one beat
// base/len: start address and beats-minus-one; adr: current beat address; last: final beat
module wb_cmd_beat_ctr #(
  parameter int AW = 32,
  parameter int LEN_W = 4,
  parameter int STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic [AW-1:0]    base,
  input  logic [LEN_W-1:0] len,
  output logic [AW-1:0]    adr,
  output logic             last
);
  logic [LEN_W-1:0] idx;
  always_ff @(posedge clk)
    if (rst || clr) idx <= '0;
    else if (step) idx <= idx + 1'b1;
  // address is recomputed from the base so it wraps modulo 2^AW for free
  assign adr = base + AW'(idx) * AW'(STEP);
  assign last = idx == len;
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command stream to Wishbone classic single/burst cycles, one response per beat
// cmd_*: command in (we, sel, adr, wdata, len = beats-1); rsp_*: per-beat response out
// wbm_*: Wishbone classic initiator; wb_clk_i clock, wb_rst_i sync active-high reset
// Optional per-beat ack timeout: define WB_CMD_MASTER_TIMEOUT_EN
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int AW = CMD_AW,
  parameter int DW = CMD_DW,
  parameter int LEN_W = CMD_LEN_W,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [DW/8-1:0]   wbm_sel_o,
  output logic [AW-1:0]     wbm_adr_o,
  output logic [DW-1:0]     wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DW-1:0]     wbm_dat_i
);
  state_t state, next;
  cmd_t cmd_in, cmd_q;
  logic [DW-1:0] rdata_q;
  logic err_q, last, timeout, beat_end;
  assign cmd_in = '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, wdata: cmd_wdata, len: cmd_len};
`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic [31:0] tcnt;
  // counter sits at zero outside BUS, so each beat starts counting from zero
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i || state != BUS) tcnt <= '0;
    else tcnt <= tcnt + 32'd1;
  assign timeout = state == BUS && !wbm_ack_i && tcnt == TIMEOUT - 1;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout = 1'b0;
`endif
  assign beat_end = state == BUS && (wbm_ack_i || timeout);
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) state <= IDLE;
    else state <= next;
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      cmd_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) cmd_q <= cmd_in;
      if (beat_end) begin
        rdata_q <= (cmd_q.we || !wbm_ack_i) ? '0 : wbm_dat_i;
        err_q <= !wbm_ack_i;
      end
    end
  always_comb
    next = state == IDLE ? (cmd_valid ? BUS : IDLE) :
           state == BUS  ? (beat_end ? RESP : BUS) :
           rsp_ready     ? (rsp_last ? IDLE : BUS) : RESP;
  wb_cmd_beat_ctr #(.AW(AW), .LEN_W(LEN_W), .STEP(DW / 8)) u_beat (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .clr(state == IDLE),
    .step(state == RESP && rsp_ready && !rsp_last),
    .base(cmd_q.adr),
    .len(cmd_q.len),
    .adr(wbm_adr_o),
    .last(last)
  );
  always_comb begin
    cmd_ready = state == IDLE;
    wbm_cyc_o = state == BUS;
    wbm_stb_o = state == BUS;
    wbm_we_o = cmd_q.we;
    wbm_sel_o = cmd_q.sel;
    wbm_dat_o = cmd_q.wdata;
    rsp_valid = state == RESP;
    rsp_rdata = rdata_q;
    rsp_err = err_q;
    // a timed-out beat aborts the rest of the burst, so it is reported as last
    rsp_last = state == RESP && (last || err_q);
  end
endmodule
